fetch_ctrl: RTL and testbench

Fetch-stage sequencing controller for the dynamically predicted 5-stage pipeline. It owns the architectural fetch PC and, each cycle, selects the next one from these sources:
- predictor target,
- EX-stage branch correction,
- interrupt vector / ERET return,
- hold.

It tracks halt and in-handler state, latches interrupts that arrive while one is being serviced, and generates the pipeline flush. It sits between the predictor/instruction store and the EX-stage branch resolution logic.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl_sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Pipeline-wide constants shared by the fetch stage: FSM state encoding,
// the next-PC source select, and the default reset PC.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ISR    = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_PRE  = 2'd0,
    SEL_NPC  = 2'd1,
    SEL_INT  = 2'd2,
    SEL_HOLD = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (RST) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: picks the next PC from predictor, EX correction,
// interrupt/ERET vector or hold; tracks RUN/HALTED/ISR and pending interrupts.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             stall,
  input  logic             halt,
  input  logic             interrupt,
  input  logic             eret,
  input  logic [31:0]      int_pc,
  input  logic [31:0]      pc_pre,
  input  logic             branch_old,
  input  logic             preright_old,
  input  logic [31:0]      pc_npc,
  output logic [31:0]      pc_now,
  output logic             flush,
  output logic             halted,
  output logic             in_isr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         int_pend_reg, int_pend_next;
  pc_sel_t      pc_sel;

  logic mispredict, int_take, eret_take;
  logic branch_acc, mispred_acc;

  always_comb begin
    mispredict  = branch_old & ~preright_old;
    int_take    = (interrupt | int_pend_reg) && (state_reg != ISR);
    eret_take   = eret && (state_reg == ISR);
    // A halted pipeline has nothing in EX worth counting or redirecting on.
    branch_acc  = branch_old && (state_reg != HALTED);
    mispred_acc = branch_acc && ~preright_old;
  end

  always_comb begin
    state_next    = state_reg;
    pc_sel        = SEL_PRE;
    flush         = 1'b0;
    int_pend_next = int_pend_reg;

    if (int_take) begin
      pc_sel     = SEL_INT;
      state_next = ISR;
      flush      = 1'b1;
    end else if (eret_take) begin
      pc_sel     = SEL_INT;
      state_next = RUN;
      flush      = 1'b1;
    end else if (mispredict && (state_reg != HALTED)) begin
      // Any halt this cycle came from a younger, squashed instruction.
      pc_sel = SEL_NPC;
      flush  = 1'b1;
    end else if (halt && (state_reg != HALTED)) begin
      pc_sel     = SEL_HOLD;
      state_next = HALTED;
    end else if (stall || (state_reg == HALTED)) begin
      pc_sel = SEL_HOLD;
    end

    // An interrupt that is not taken can only be one arriving during ISR.
    if (int_take) begin
      int_pend_next = 1'b0;
    end else if (interrupt) begin
      int_pend_next = 1'b1;
    end
  end

  always_comb begin
    case (pc_sel)
      SEL_PRE: pc_next = pc_pre;
      SEL_NPC: pc_next = pc_npc;
      SEL_INT: pc_next = int_pc;
      default: pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      int_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      int_pend_reg <= int_pend_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc   (branch_acc),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc   (mispred_acc),
    .count (mispred_cnt)
  );

  assign pc_now = pc_reg;
  assign halted = (state_reg == HALTED);
  assign in_isr = (state_reg == ISR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a second instance with 4-bit counters
// shares the stimulus so counter saturation is reachable quickly.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        RST, stall, halt, interrupt, eret;
  logic [31:0] int_pc, pc_pre, pc_npc;
  logic        branch_old, preright_old;

  logic [31:0] pc_now, pc_now_s;
  logic        flush, halted, in_isr;
  logic        flush_s, halted_s, in_isr_s;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [3:0]  branch_cnt_s, mispred_cnt_s;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .RST(RST), .stall(stall), .halt(halt), .interrupt(interrupt),
    .eret(eret), .int_pc(int_pc), .pc_pre(pc_pre), .branch_old(branch_old),
    .preright_old(preright_old), .pc_npc(pc_npc), .pc_now(pc_now),
    .flush(flush), .halted(halted), .in_isr(in_isr),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut_s (
    .clk(clk), .RST(RST), .stall(stall), .halt(halt), .interrupt(interrupt),
    .eret(eret), .int_pc(int_pc), .pc_pre(pc_pre), .branch_old(branch_old),
    .preright_old(preright_old), .pc_npc(pc_npc), .pc_now(pc_now_s),
    .flush(flush_s), .halted(halted_s), .in_isr(in_isr_s),
    .branch_cnt(branch_cnt_s), .mispred_cnt(mispred_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %s ok: %h", tag, obs);
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; halt = 0; interrupt = 0; eret = 0;
    branch_old = 0; preright_old = 0;
  endtask

  initial begin
    RST = 1; idle();
    int_pc = 0; pc_pre = 0; pc_npc = 0;
    cycle();
    cycle();
    RST = 0;
    #1;
    chk("rst_pc", pc_now, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_in_isr", {31'b0, in_isr}, 32'h0);
    chk("rst_bcnt", {16'b0, branch_cnt}, 32'h0);
    chk("rst_mcnt", {16'b0, mispred_cnt}, 32'h0);

    // Free-running sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_now, 32'(i * 4));
      chk("seq_flush", {31'b0, flush}, 32'h0);
      pc_pre = 32'(i * 4 + 4);
      cycle();
    end
    chk("seq_pc_end", pc_now, 32'h10);

    // Mispredict overrides stall
    branch_old = 1; preright_old = 0; pc_npc = 32'h100; stall = 1; pc_pre = 32'h14;
    #1 chk("misp_flush", {31'b0, flush}, 32'h1);
    cycle(); idle();
    chk("misp_pc", pc_now, 32'h100);
    chk("misp_mcnt", {16'b0, mispred_cnt}, 32'h1);
    chk("misp_bcnt", {16'b0, branch_cnt}, 32'h1);

    // Correctly predicted branch
    branch_old = 1; preright_old = 1; pc_pre = 32'h104; pc_npc = 32'h555;
    #1 chk("ok_br_flush", {31'b0, flush}, 32'h0);
    cycle(); idle();
    chk("ok_br_pc", pc_now, 32'h104);
    chk("ok_br_bcnt", {16'b0, branch_cnt}, 32'h2);
    chk("ok_br_mcnt", {16'b0, mispred_cnt}, 32'h1);

    // Plain stall
    stall = 1; pc_pre = 32'h108;
    cycle(); idle();
    chk("stall_pc", pc_now, 32'h104);

    // Interrupt entry
    interrupt = 1; int_pc = 32'h800; pc_pre = 32'h108;
    #1 chk("int_flush", {31'b0, flush}, 32'h1);
    cycle(); idle();
    chk("int_pc", pc_now, 32'h800);
    chk("int_in_isr", {31'b0, in_isr}, 32'h1);

    pc_pre = 32'h804;
    cycle();
    chk("isr_seq_pc", pc_now, 32'h804);

    // Second interrupt while in ISR gets latched, not taken
    interrupt = 1; int_pc = 32'h900; pc_pre = 32'h808;
    #1 chk("int2_flush", {31'b0, flush}, 32'h0);
    cycle(); idle();
    chk("int2_pc", pc_now, 32'h808);
    chk("int2_in_isr", {31'b0, in_isr}, 32'h1);

    eret = 1; int_pc = 32'h40; pc_pre = 32'h80c;
    #1 chk("eret_flush", {31'b0, flush}, 32'h1);
    cycle(); idle();
    chk("eret_pc", pc_now, 32'h40);
    chk("eret_in_isr", {31'b0, in_isr}, 32'h0);

    // Pending interrupt taken the cycle after eret
    int_pc = 32'h880; pc_pre = 32'h44;
    #1 chk("pend_flush", {31'b0, flush}, 32'h1);
    cycle();
    chk("pend_pc", pc_now, 32'h880);
    chk("pend_in_isr", {31'b0, in_isr}, 32'h1);

    eret = 1; int_pc = 32'h44; pc_pre = 32'h884;
    cycle(); idle();
    chk("eret2_pc", pc_now, 32'h44);
    pc_pre = 32'h48;
    #1 chk("nopend_flush", {31'b0, flush}, 32'h0);
    cycle();
    chk("nopend_pc", pc_now, 32'h48);

    // Halt freezes fetch; branches ignored
    halt = 1; pc_pre = 32'h4c;
    #1 chk("halt_flush", {31'b0, flush}, 32'h0);
    cycle(); idle();
    chk("halt_halted", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc_now, 32'h48);
    for (int i = 0; i < 5; i++) begin
      branch_old = 1; preright_old = i[0]; pc_npc = 32'h777; pc_pre = 32'h999;
      #1 chk("halted_flush", {31'b0, flush}, 32'h0);
      cycle();
      chk("halted_pc", pc_now, 32'h48);
    end
    idle();
    chk("halted_bcnt", {16'b0, branch_cnt}, 32'h2);
    chk("halted_mcnt", {16'b0, mispred_cnt}, 32'h1);

    interrupt = 1; int_pc = 32'h800;
    #1 chk("wake_flush", {31'b0, flush}, 32'h1);
    cycle(); idle();
    chk("wake_pc", pc_now, 32'h800);
    chk("wake_halted", {31'b0, halted}, 32'h0);
    chk("wake_in_isr", {31'b0, in_isr}, 32'h1);

    eret = 1; int_pc = 32'h50;
    cycle(); idle();
    chk("eret3_pc", pc_now, 32'h50);

    // Halt and mispredict together: mispredict wins
    halt = 1; branch_old = 1; preright_old = 0; pc_npc = 32'h200; pc_pre = 32'h54;
    #1 chk("hm_flush", {31'b0, flush}, 32'h1);
    cycle(); idle();
    chk("hm_pc", pc_now, 32'h200);
    chk("hm_halted", {31'b0, halted}, 32'h0);
    chk("hm_bcnt", {16'b0, branch_cnt}, 32'h3);
    chk("hm_mcnt", {16'b0, mispred_cnt}, 32'h2);

    // eret outside ISR is ignored
    eret = 1; int_pc = 32'h600; pc_pre = 32'h204;
    #1 chk("eret_run_flush", {31'b0, flush}, 32'h0);
    cycle(); idle();
    chk("eret_run_pc", pc_now, 32'h204);
    chk("eret_run_isr", {31'b0, in_isr}, 32'h0);

    // Saturation on the 4-bit instance (starts at bcnt=3, mcnt=2)
    for (int i = 0; i < 11; i++) begin
      branch_old = 1; preright_old = 0; pc_npc = 32'h204;
      cycle();
    end
    chk("sat_s_b14", {28'b0, branch_cnt_s}, 32'd14);
    chk("sat_s_m13", {28'b0, mispred_cnt_s}, 32'd13);
    for (int i = 0; i < 4; i++) cycle();
    chk("sat_s_b15", {28'b0, branch_cnt_s}, 32'd15);
    chk("sat_s_m15", {28'b0, mispred_cnt_s}, 32'd15);
    chk("sat_main_b", {16'b0, branch_cnt}, 32'd18);
    cycle(); idle();
    chk("sat_s_hold_b", {28'b0, branch_cnt_s}, 32'd15);
    chk("sat_s_hold_m", {28'b0, mispred_cnt_s}, 32'd15);
    chk("sat_main_b2", {16'b0, branch_cnt}, 32'd19);
    chk("sat_main_m2", {16'b0, mispred_cnt}, 32'd18);

    // Reset during a redirect
    interrupt = 1; int_pc = 32'h800; RST = 1;
    cycle(); idle(); RST = 0;
    chk("rst_mid_pc", pc_now, 32'h0);
    chk("rst_mid_isr", {31'b0, in_isr}, 32'h0);
    chk("rst_mid_bcnt", {16'b0, branch_cnt}, 32'h0);
    pc_pre = 32'h4;
    #1 chk("rst_mid_nopend", {31'b0, flush}, 32'h0);
    cycle();
    chk("rst_mid_seq", pc_now, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
